collision_checker: RTL and testbench
====================================

Name: collision_checker

Overview:
- Sequential collision and game-over checker for the Tetris playfield, generalised to any grid size and piece footprint.
- Takes a request carrying a PIECE_N x PIECE_N occupancy mask, an anchor row/col and a check mode, then scans the mask one cell per cycle against a snapshot of the grid.
- Reports collision, wall/floor violation, and a sticky game_over flag for failed spawn checks.
- Sits between the piece-control FSM (requester) and the grid register file.

Parameters:
- GRID_W, 10, playfield columns.
- GRID_H, 30, playfield rows; grid bit index = row*GRID_W + col, row 0 = top.
- PIECE_N, 4, piece footprint edge; mask bit k maps to cell (k / PIECE_N, k % PIECE_N).
- RW, $clog2(GRID_H+PIECE_N), anchor row width.
- CW, $clog2(GRID_W+PIECE_N), anchor col width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when the block is IDLE and can accept a request.
- req_mode  in  1  0 = MOVE check, 1 = SPAWN check.
- req_mask  in  PIECE_N*PIECE_N  piece occupancy mask.
- req_row  in  RW  anchor row (top of footprint).
- req_col  in  CW  anchor column (left of footprint).
- grid  in  GRID_W*GRID_H  occupied-cell vector.
- clear_over  in  1  clears game_over.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_collide  out  1  an occupied grid cell overlaps a mask cell.
- rsp_oob  out  1  a mask cell lies at col >= GRID_W or row >= GRID_H.
- game_over  out  1  sticky, set by a failed SPAWN check.

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready = 1; rsp_valid, rsp_collide, rsp_oob and game_over all 0; scan index 0; snapshot registers 0.
- FSM states: IDLE, SCAN, RESP.
- IDLE: on req_valid && req_ready, latch mode, mask, row, col and the full grid snapshot; k = 0; go to SCAN.
- SCAN: one mask bit per cycle, k = 0 .. PIECE_N*PIECE_N-1.
  - If mask[k] = 1: r = row + k/PIECE_N and c = col + k%PIECE_N, computed at RW+1/CW+1 bits with no wrap.
  - If c >= GRID_W or r >= GRID_H: set oob. The grid is not indexed for that cell.
  - Otherwise, if snapshot[r*GRID_W + c] = 1: set collide.
- Early exit: the first hit moves to RESP. Otherwise go to RESP after the last k.
- Latency: accept to rsp_valid = (index of first hit, or PIECE_N*PIECE_N-1) + 2 cycles; 17 cycles max with defaults.
- Empty mask: full scan; both flags 0.
- RESP:
  - rsp_valid = 1 for exactly one cycle; flags are valid in that cycle and held until the next accept.
  - If mode = SPAWN and (collide or oob): set game_over.
  - Return to IDLE; req_ready reasserts the cycle after RESP.
- req_ready = 0 in SCAN and RESP. req_valid in those states is ignored, not queued.
- Grid changes during SCAN have no effect, because the snapshot is used.
- game_over:
  - Once set, holds until clear_over or reset.
  - Setting and clear_over in the same cycle: set wins.
  - game_over does not block further requests.
- MOVE-mode hits never touch game_over.
- rsp_collide and rsp_oob clear on the next accept.
- Reset mid-scan: abort to IDLE and clear all outputs, including game_over.

Decomposition:
- Shared package tetris_pkg holds:
  - the GRID_W, GRID_H and PIECE_N defaults;
  - the mode encodings MODE_MOVE = 1'b0 and MODE_SPAWN = 1'b1;
  - the FSM state enum.
- One natural sub-module: cell_probe. It is combinational, takes (row, col, k, snapshot) and returns {oob, hit}.
- Everything else stays in collision_checker.

Test Plan:
- Empty grid, MOVE, mask 16'h0033 (O piece), row 0, col 0 -> rsp_valid 17 cycles after accept; collide = 0, oob = 0, game_over = 0.
- grid bit 21 (row 2, col 1) = 1, MOVE, mask 16'h0033, row 1, col 0 -> cell (2,1) is mask bit 5; rsp_valid at cycle 7 with collide = 1, oob = 0.
- Empty grid, MOVE, mask 16'h0033, row 0, col 9 -> mask bit 1 gives c = 10; oob = 1 at cycle 3; collide = 0.
- grid bit 4 = 1, SPAWN, mask 16'h0033, row 0, col 3 -> collide = 1 and game_over rises after RESP. A subsequent MOVE request with no hit leaves game_over = 1. Pulsing clear_over then clears it.
- Toggle all grid bits and hold req_valid during SCAN -> result matches the accept-time snapshot; exactly one rsp_valid; the next request is accepted only after req_ready returns.
- Drop rst_n mid-SCAN with game_over = 1 -> all outputs 0 immediately; req_ready = 1 after release; no rsp_valid.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared defaults, check-mode encodings and FSM state type for the playfield
// collision checker.
package tetris_pkg;
  localparam int GRID_W_DEF  = 10;
  localparam int GRID_H_DEF  = 30;
  localparam int PIECE_N_DEF = 4;

  localparam logic MODE_MOVE  = 1'b0;
  localparam logic MODE_SPAWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESP
  } state_e;
endpackage

// File: rtl/collision_checker_cell_probe.sv
// Combinational probe of one footprint cell: maps mask index k at the anchor to
// a grid cell and reports whether it is out of bounds or lands on an occupied cell.
module cell_probe #(
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 30,
  parameter int PIECE_N = 4,
  parameter int RW      = 6,
  parameter int CW      = 4,
  parameter int KW      = 4
) (
  input  logic [RW-1:0]            row,
  input  logic [CW-1:0]            col,
  input  logic [KW-1:0]            k,
  input  logic [GRID_W*GRID_H-1:0] snapshot,
  output logic                     oob,
  output logic                     hit
);
  localparam int IW = $clog2(GRID_W*GRID_H);

  logic [RW:0]   r;
  logic [CW:0]   c;
  logic [IW-1:0] idx;

  always_comb begin
    // One extra bit so anchors near the top of the range never wrap back in.
    r   = (RW+1)'(row) + (RW+1)'(int'(k) / PIECE_N);
    c   = (CW+1)'(col) + (CW+1)'(int'(k) % PIECE_N);
    oob = (r >= (RW+1)'(GRID_H)) || (c >= (CW+1)'(GRID_W));
    idx = '0;
    if (!oob) idx = IW'(int'(r) * GRID_W + int'(c));
    hit = !oob && snapshot[idx];
  end
endmodule

// File: rtl/collision_checker.sv
// Sequential collision / game-over checker: scans a piece mask one cell per
// cycle against a grid snapshot taken at accept time, exiting on the first hit.
module collision_checker
  import tetris_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int PIECE_N = PIECE_N_DEF,
  parameter int RW      = $clog2(GRID_H + PIECE_N),
  parameter int CW      = $clog2(GRID_W + PIECE_N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_mode,
  input  logic [PIECE_N*PIECE_N-1:0]   req_mask,
  input  logic [RW-1:0]                req_row,
  input  logic [CW-1:0]                req_col,
  input  logic [GRID_W*GRID_H-1:0]     grid,
  input  logic                         clear_over,
  output logic                         rsp_valid,
  output logic                         rsp_collide,
  output logic                         rsp_oob,
  output logic                         game_over
);
  localparam int NCELL = PIECE_N * PIECE_N;
  localparam int KW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  state_e                     state_q, state_d;
  logic                       mode_q, mode_d;
  logic [NCELL-1:0]           mask_q, mask_d;
  logic [RW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic [GRID_W*GRID_H-1:0]   snap_q, snap_d;
  logic [KW-1:0]              k_q, k_d;
  logic                       collide_q, collide_d;
  logic                       oob_q, oob_d;
  logic                       over_q, over_d;
  logic                       p_oob, p_hit;

  cell_probe #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .PIECE_N(PIECE_N),
    .RW     (RW),
    .CW     (CW),
    .KW     (KW)
  ) u_probe (
    .row     (row_q),
    .col     (col_q),
    .k       (k_q),
    .snapshot(snap_q),
    .oob     (p_oob),
    .hit     (p_hit)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    row_d     = row_q;
    col_d     = col_q;
    snap_d    = snap_q;
    k_d       = k_q;
    collide_d = collide_q;
    oob_d     = oob_q;
    // Clear first so a same-cycle set below takes priority.
    over_d    = over_q & ~clear_over;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mode_d    = req_mode;
          mask_d    = req_mask;
          row_d     = req_row;
          col_d     = req_col;
          snap_d    = grid;
          k_d       = '0;
          collide_d = 1'b0;
          oob_d     = 1'b0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mask_q[k_q] && (p_oob || p_hit)) begin
          oob_d     = p_oob;
          collide_d = p_hit;
          state_d   = ST_RESP;
        end else if (k_q == KW'(NCELL - 1)) begin
          state_d = ST_RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (mode_q == MODE_SPAWN && (collide_q || oob_q)) over_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MOVE;
      mask_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      snap_q    <= '0;
      k_q       <= '0;
      collide_q <= 1'b0;
      oob_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      row_q     <= row_d;
      col_q     <= col_d;
      snap_q    <= snap_d;
      k_q       <= k_d;
      collide_q <= collide_d;
      oob_q     <= oob_d;
      over_q    <= over_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_collide = collide_q;
  assign rsp_oob     = oob_q;
  assign game_over   = over_q;
endmodule

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker: expected flags/latency queued at drive
// time and compared when rsp_valid is seen.
module tb_collision_checker;
  localparam int GW = 10;
  localparam int GH = 30;
  localparam int PN = 4;
  localparam int RW = $clog2(GH + PN);
  localparam int CW = $clog2(GW + PN);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_mode = 1'b0;
  logic [PN*PN-1:0]     req_mask = '0;
  logic [RW-1:0]        req_row = '0;
  logic [CW-1:0]        req_col = '0;
  logic [GW*GH-1:0]     grid = '0;
  logic                 clear_over = 1'b0;
  logic                 rsp_valid, rsp_collide, rsp_oob, game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic c;
    logic o;
    int   lat;
  } exp_t;
  exp_t sb[$];

  collision_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_mask   (req_mask),
    .req_row    (req_row),
    .req_col    (req_col),
    .grid       (grid),
    .clear_over (clear_over),
    .rsp_valid  (rsp_valid),
    .rsp_collide(rsp_collide),
    .rsp_oob    (rsp_oob),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // flags: bit0 = hold req_valid and invert grid mid-scan, bit1 = pulse clear_over in RESP
  task automatic do_req(input logic mode, input logic [PN*PN-1:0] mask,
                        input logic [RW-1:0] row, input logic [CW-1:0] col,
                        input logic ec, input logic eo, input int elat, input int flags);
    exp_t e;
    int   cyc;
    bit   seen;
    sb.push_back('{c: ec, o: eo, lat: elat});
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_mode = mode; req_mask = mask; req_row = row; req_col = col;
    @(posedge clk);
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (flags[0] == 1'b0) req_valid = 1'b0;
      if (cyc == 1) check("ready_scan", req_ready, 0);
      if (flags[0] && cyc == 2) grid = ~grid;
      if (rsp_valid) seen = 1;
    end
    req_valid = 1'b0;
    if (flags[1]) clear_over = 1'b1;
    e = sb.pop_front();
    check("rsp_seen", seen, 1);
    check("latency", cyc, e.lat);
    check("collide", rsp_collide, e.c);
    check("oob", rsp_oob, e.o);
    @(negedge clk);
    clear_over = 1'b0;
    check("one_pulse", rsp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  initial begin
    int pulses;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_collide", rsp_collide, 0);
    check("rst_oob", rsp_oob, 0);
    check("rst_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // O piece on empty grid: full scan, no flags
    do_req(1'b0, 16'h0033, 0, 0, 1'b0, 1'b0, 17, 0);
    check("over_move", game_over, 0);
    // occupied (2,1) hit by mask bit 5
    grid[21] = 1'b1;
    do_req(1'b0, 16'h0033, 1, 0, 1'b1, 1'b0, 7, 0);
    grid = '0;
    // right wall on mask bit 1
    do_req(1'b0, 16'h0033, 0, 9, 1'b0, 1'b1, 3, 0);
    // floor on mask bit 4
    do_req(1'b0, 16'h0033, 29, 0, 1'b0, 1'b1, 6, 0);
    // anchor row at max: no wrap, oob on bit 0
    do_req(1'b0, 16'h0001, 63, 0, 1'b0, 1'b1, 2, 0);
    // anchor col at max: oob on bit 0
    do_req(1'b0, 16'h0001, 0, 15, 1'b0, 1'b1, 2, 0);
    // empty mask over a full grid: full scan, no flags
    grid = '1;
    do_req(1'b0, 16'h0000, 0, 0, 1'b0, 1'b0, 17, 0);
    // last cell (29,9) via mask bit 15
    do_req(1'b0, 16'h8000, 26, 6, 1'b1, 1'b0, 17, 0);
    grid = '0;
    check("over_still0", game_over, 0);

    // failed spawn raises game_over after RESP
    grid[4] = 1'b1;
    do_req(1'b1, 16'h0033, 0, 3, 1'b1, 1'b0, 3, 0);
    check("over_set", game_over, 1);
    do_req(1'b0, 16'h0033, 5, 0, 1'b0, 1'b0, 17, 0);
    check("over_sticky", game_over, 1);
    @(negedge clk); clear_over = 1'b1;
    @(negedge clk); clear_over = 1'b0;
    check("over_clear", game_over, 0);
    // set beats a simultaneous clear
    do_req(1'b1, 16'h0033, 0, 3, 1'b1, 1'b0, 3, 2);
    check("over_set_wins", game_over, 1);
    grid = '0;

    // snapshot: grid inverted mid-scan and req_valid held
    do_req(1'b0, 16'h0033, 0, 0, 1'b0, 1'b0, 17, 1);
    grid = '0;
    check("over_after_hold", game_over, 1);

    // async reset mid-scan
    @(negedge clk);
    req_valid = 1'b1; req_mode = 1'b0; req_mask = 16'h0033; req_row = 0; req_col = 0;
    @(posedge clk);
    repeat (4) @(negedge clk);
    req_valid = 1'b0;
    check("scan_busy", req_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_collide", rsp_collide, 0);
    check("mid_rst_oob", rsp_oob, 0);
    check("mid_rst_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("no_rsp_after_rst", pulses, 0);
    check("ready_after_rst", req_ready, 1);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
